io_register_file: RTL and testbench

IO_REGISTER_FILE -- requirements
Module: io_register_file

---
 rtl/io_pkg.sv | 18 +
 rtl/io_register_file.sv | 61 ++++++
 tb/tb_io_register_file.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared word type and channel map for the IO register file.
// Channels 0..4 are read-only input samples; CH_RW_FIRST and up are core-writable.
package io_pkg;

  localparam int WORD_W = 15;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] CH_VERB         = 4'd0;
  localparam logic [SEL_W-1:0] CH_NOUN         = 4'd1;
  localparam logic [SEL_W-1:0] CH_MISSION_TIME = 4'd2;
  localparam logic [SEL_W-1:0] CH_APOGEE       = 4'd3;
  localparam logic [SEL_W-1:0] CH_PERIGEE      = 4'd4;
  localparam logic [SEL_W-1:0] CH_RW_FIRST     = 4'd5;

  typedef logic [WORD_W-1:0] io_word_t;

endpackage

// File: rtl/io_register_file.sv
// Channel register file: five sampled input words plus core-writable registers, one read port.
// Latency: read data registered one cycle after select (inputs two); no backpressure, updates every cycle.
module io_register_file
  import io_pkg::*;
#(
  parameter int WORD_W = io_pkg::WORD_W,
  parameter int NUM_CH = io_pkg::NUM_CH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_write,
  input  logic [SEL_W-1:0]  sel_write,
  input  logic              en_write,
  input  logic [SEL_W-1:0]  sel_read,
  output logic [WORD_W-1:0] data_read,
  input  logic [WORD_W-1:0] data_DSKY_VERB,
  input  logic [WORD_W-1:0] data_DSKY_NOUN,
  input  logic [WORD_W-1:0] data_AXI_MISSION_TIME,
  input  logic [WORD_W-1:0] data_AXI_APOGEE,
  input  logic [WORD_W-1:0] data_AXI_PERIGEE
);

  // Entries below CH_RW_FIRST hold input samples, the rest are channel registers.
  logic [WORD_W-1:0] regs [NUM_CH];
  logic [WORD_W-1:0] rd_next;
  logic              wr_hit;

  assign wr_hit = en_write && (sel_write >= CH_RW_FIRST) && (int'(sel_write) < NUM_CH);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        regs[i] <= '0;
      end
      data_read <= '0;
    end else begin
      regs[CH_VERB]         <= data_DSKY_VERB;
      regs[CH_NOUN]         <= data_DSKY_NOUN;
      regs[CH_MISSION_TIME] <= data_AXI_MISSION_TIME;
      regs[CH_APOGEE]       <= data_AXI_APOGEE;
      regs[CH_PERIGEE]      <= data_AXI_PERIGEE;
      for (int i = int'(CH_RW_FIRST); i < NUM_CH; i++) begin
        if (wr_hit && (int'(sel_write) == i)) begin
          regs[i] <= data_write;
        end
      end
      data_read <= rd_next;
    end
  end

  // Write-first: a same-cycle write to the selected channel bypasses the array.
  always_comb begin
    rd_next = '0;
    if (wr_hit && (sel_write == sel_read)) begin
      rd_next = data_write;
    end else if (int'(sel_read) < NUM_CH) begin
      rd_next = regs[sel_read];
    end
  end

endmodule

// File: tb/tb_io_register_file.sv
// Directed vectors with hand-computed read data; a monitor pops expectations after every edge.
module tb_io_register_file;
  import io_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [3:0]  ws;
    logic [14:0] wd;
    logic [3:0]  rs;
    logic [14:0] verb, noun, mt, ap, pe;
    logic [14:0] exp_rd;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] data_write = '0;
  logic [3:0]  sel_write = '0;
  logic        en_write = 1'b0;
  logic [3:0]  sel_read = '0;
  logic [14:0] data_read;
  logic [14:0] verb = '0, noun = '0, mt = '0, ap = '0, pe = '0;

  int checks = 0;
  int failures = 0;

  vec_t  vecs [$];
  string names [$];
  logic [14:0] exp_q [$];
  string       name_q [$];
  logic [14:0] cur_verb, cur_noun, cur_mt, cur_ap, cur_pe;

  io_register_file dut (
    .clock(clock), .reset(reset), .data_write(data_write), .sel_write(sel_write),
    .en_write(en_write), .sel_read(sel_read), .data_read(data_read),
    .data_DSKY_VERB(verb), .data_DSKY_NOUN(noun), .data_AXI_MISSION_TIME(mt),
    .data_AXI_APOGEE(ap), .data_AXI_PERIGEE(pe)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic we, input logic [3:0] ws,
                     input logic [14:0] wd, input logic [3:0] rs,
                     input logic [14:0] e, input string nm);
    vec_t v;
    v.rst = rst; v.we = we; v.ws = ws; v.wd = wd; v.rs = rs;
    v.verb = cur_verb; v.noun = cur_noun; v.mt = cur_mt; v.ap = cur_ap; v.pe = cur_pe;
    v.exp_rd = e;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic build();
    cur_verb = 15'h0111; cur_noun = 15'h0222; cur_mt = 15'h0333;
    cur_ap = 15'h0444; cur_pe = 15'h0555;
    add(1, 0, 4'd0, 15'h0000, 4'd0, 15'h0000, "reset_rd");
    add(1, 1, 4'd6, 15'h2222, 4'd0, 15'h0000, "reset_wr_discard");
    add(0, 0, 4'd0, 15'h0000, 4'd0, 15'h0000, "first_after_reset_sample0");
    add(0, 0, 4'd0, 15'h0000, 4'd0, 15'h0111, "verb_sampled");
    for (int c = 5; c < 16; c++) begin
      add(0, 0, 4'd0, 15'h0000, 4'(c), 15'h0000, $sformatf("rw_reset_ch%0d", c));
    end
    add(0, 1, 4'd7, 15'h1234, 4'd5, 15'h0000, "write7_read5");
    add(0, 0, 4'd0, 15'h0000, 4'd7, 15'h1234, "read7");
    add(0, 1, 4'd15, 15'h7FFF, 4'd15, 15'h7FFF, "fwd15");
    add(0, 0, 4'd0, 15'h0000, 4'd15, 15'h7FFF, "read15");
    add(0, 1, 4'd8, 15'h0AAA, 4'd7, 15'h1234, "write8_read7_old");
    add(0, 0, 4'd0, 15'h0000, 4'd8, 15'h0AAA, "read8");
    add(0, 0, 4'd10, 15'h7777, 4'd10, 15'h0000, "we0_no_fwd");
    cur_verb = 15'd37;
    add(0, 1, 4'd0, 15'h5555, 4'd0, 15'h0111, "verb_old_before_edge");
    add(0, 1, 4'd4, 15'h5555, 4'd0, 15'd37, "verb_2cycle");
    add(0, 0, 4'd0, 15'h0000, 4'd4, 15'h0555, "perigee_wr_ignored");
    add(0, 0, 4'd0, 15'h0000, 4'd5, 15'h0000, "ch5_unchanged");
    add(0, 0, 4'd0, 15'h0000, 4'd7, 15'h1234, "ch7_unchanged");
    cur_noun = 15'h0011; cur_mt = 15'h0100; cur_ap = 15'h2000; cur_pe = 15'h0003;
    add(0, 0, 4'd0, 15'h0000, 4'd1, 15'h0222, "noun_old");
    add(0, 0, 4'd0, 15'h0000, 4'd1, 15'h0011, "noun");
    add(0, 0, 4'd0, 15'h0000, 4'd2, 15'h0100, "mission_time");
    add(0, 0, 4'd0, 15'h0000, 4'd3, 15'h2000, "apogee");
    add(0, 0, 4'd0, 15'h0000, 4'd4, 15'h0003, "perigee");
    add(0, 1, 4'd9, 15'h0ABC, 4'd9, 15'h0ABC, "fwd9");
    add(0, 0, 4'd0, 15'h0000, 4'd9, 15'h0ABC, "read9");
    add(1, 0, 4'd0, 15'h0000, 4'd9, 15'h0000, "mid_reset_rd");
    add(0, 0, 4'd0, 15'h0000, 4'd0, 15'h0000, "sample_cleared");
    add(0, 0, 4'd0, 15'h0000, 4'd9, 15'h0000, "ch9_cleared");
    add(0, 0, 4'd0, 15'h0000, 4'd7, 15'h0000, "ch7_cleared");
    add(0, 0, 4'd0, 15'h0000, 4'd0, 15'd37, "verb_resumed");
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        logic [14:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (data_read !== e) begin
          failures++;
          $display("FAIL %s: data_read=%h expected=%h", nm, data_read, e);
        end
      end
    end
  end

  initial begin : stim
    build();
    foreach (vecs[k]) begin
      @(negedge clock);
      reset = vecs[k].rst;
      en_write = vecs[k].we;
      sel_write = vecs[k].ws;
      data_write = vecs[k].wd;
      sel_read = vecs[k].rs;
      verb = vecs[k].verb; noun = vecs[k].noun; mt = vecs[k].mt;
      ap = vecs[k].ap; pe = vecs[k].pe;
      exp_q.push_back(vecs[k].exp_rd);
      name_q.push_back(names[k]);
    end
    @(negedge clock);
    en_write = 1'b0;
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
